// File: rtl/slicer_pkg.sv
// Shared types and sizing helpers for the word slicer.
package slicer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned MIN_IDX_W = 1;

  function automatic int unsigned slice_count(input int unsigned n, input int unsigned m);
    return n / m;
  endfunction

  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/slice_mux.sv
// Selects one M-bit slice of an N-bit word by index.
// Slice ordering is LSB-first unless SLICER_MSB_FIRST_EN is defined.
module slice_mux
  import slicer_pkg::*;
#(
  parameter  int unsigned N  = 16,
  parameter  int unsigned M  = 8,
  localparam int unsigned K  = slice_count(N, M),
  localparam int unsigned IW = idx_width(K)
) (
  input  logic [N-1:0]  word,
  input  logic [IW-1:0] idx,
  output logic [M-1:0]  slice
);

  // Constant part-selects per index keep the mux free of variable shifts.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (idx == IW'(i)) begin
`ifdef SLICER_MSB_FIRST_EN
        slice = word[N-1-i*M -: M];
`else
        slice = word[i*M +: M];
`endif
      end
    end
  end

endmodule

// File: rtl/word_slicer.sv
// Width down-converter: holds an N-bit word and emits it as N/M M-bit slices
// with valid/ready on both sides. Order set by SLICER_MSB_FIRST_EN (see slice_mux).
module word_slicer
  import slicer_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned K  = slice_count(N, M);
  localparam int unsigned IW = idx_width(K);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    wreg_q, wreg_d;
  logic [M-1:0]    slice;
  logic            last;
  logic            ready_c;

  slice_mux #(.N(N), .M(M)) u_mux (
    .word  (wreg_q),
    .idx   (idx_q),
    .slice (slice)
  );

  assign last = (idx_q == IW'(K - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wreg_d    = wreg_q;
    ready_c   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        ready_c = en;
        if (en && in_valid) begin
          wreg_d  = in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = en;
        out_last  = last;
        out_data  = slice;
        ready_c   = en & out_ready & last;
        if (en && out_ready) begin
          if (!last) begin
            idx_d = idx_q + IW'(1);
          end else begin
            // Final slice: reload in the same cycle for gapless back-to-back words.
            idx_d = '0;
            if (in_valid) begin
              wreg_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = ready_c & rst_n;
  assign busy     = (state_q == SEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wreg_q  <= wreg_d;
    end
  end

endmodule

// File: tb/tb_word_slicer.sv
// Directed bench for word_slicer: 16/8 instance plus a 32/8 instance for ordering.
module tb_word_slicer;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  word_slicer #(.N(16), .M(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  word_slicer #(.N(32), .M(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic r);
    #1;
    check({tag, ".valid"}, a_out_valid, v);
    check({tag, ".data"},  a_out_data,  d);
    check({tag, ".last"},  a_out_last,  l);
    check({tag, ".ready"}, a_in_ready,  r);
  endtask

  logic [7:0] exp_b [4];

  initial begin
    rst_n = 1'b0; en = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    // Reset
    tick();
    expect_a("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst.busy", a_busy, 1'b0);
    rst_n = 1'b1;
    #1 check("rst.ready_after", a_in_ready, 1'b1);

    // Single word, out_ready high
    a_in_data = 16'hF0A5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_data = 16'h0000;
    expect_a("w1.s0", 1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    expect_a("w1.s1", 1'b1, 8'hF0, 1'b1, 1'b1);
    tick();
    #1 check("w1.busy_drop", a_busy, 1'b0);
    check("w1.valid_drop", a_out_valid, 1'b0);

    // Back-to-back words
    a_in_data = 16'h1234; a_in_valid = 1'b1;
    tick();
    a_in_data = 16'hABCD;
    expect_a("b2b.s0", 1'b1, 8'h34, 1'b0, 1'b0);
    tick();
    expect_a("b2b.s1", 1'b1, 8'h12, 1'b1, 1'b1);
    tick();
    a_in_valid = 1'b0;
    expect_a("b2b.s2", 1'b1, 8'hCD, 1'b0, 1'b0);
    tick();
    expect_a("b2b.s3", 1'b1, 8'hAB, 1'b1, 1'b1);
    tick();
    #1 check("b2b.idle", a_busy, 1'b0);

    // Backpressure on first slice
    a_in_data = 16'hF0A5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_a("bp.hold", 1'b1, 8'hA5, 1'b0, 1'b0);
      tick();
    end
    a_out_ready = 1'b1;
    expect_a("bp.release", 1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    expect_a("bp.s1", 1'b1, 8'hF0, 1'b1, 1'b1);
    tick();

    // Enable gated mid-word
    a_in_data = 16'hF0A5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    expect_a("en.s0", 1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check("en.low.valid", a_out_valid, 1'b0);
      check("en.low.ready", a_in_ready, 1'b0);
      check("en.low.busy",  a_busy, 1'b1);
      tick();
    end
    en = 1'b1;
    expect_a("en.resume", 1'b1, 8'hF0, 1'b1, 1'b1);
    tick();

    // Reset mid-word
    a_in_data = 16'hF0A5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    expect_a("mr.s0", 1'b1, 8'hA5, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("mr.valid", a_out_valid, 1'b0);
    check("mr.busy", a_busy, 1'b0);
    a_in_data = 16'h5566; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    expect_a("mr.n0", 1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    expect_a("mr.n1", 1'b1, 8'h55, 1'b1, 1'b1);
    tick();

    // 32/8 slice order
`ifdef SLICER_MSB_FIRST_EN
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
`else
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
    b_in_data = 32'hDEADBEEF; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("w32.valid", b_out_valid, 1'b1);
      check("w32.data", b_out_data, exp_b[i]);
      check("w32.last", b_out_last, (i == 3) ? 1'b1 : 1'b0);
      tick();
    end
    #1 check("w32.idle", b_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
